hb_up2_mc: RTL and testbench
============================

# hb_up2_mc

Multichannel, time-multiplexed half-band interpolate-by-2 filter with symmetric-coefficient pre-add, round-half-up scaling, output saturation and a bypass mode. It generalises the single-channel half-band interpolator: it adds up to `NUM_CH` interleaved channels with independent filter histories, explicit valid/frame signalling, and a sticky overflow flag. It sits between a TDM baseband source and the next interpolation stage. Each accepted input sample produces two output samples, delivered in parallel on one cycle.

## Interface
- `XIN_WIDTH`, 16, input sample width, signed.
- `COE_WIDTH`, 16, coefficient width, signed.
- `NUM_UNIQUE_COE`, 5, unique FIR-phase coefficients (N). Filter length is 4N-1.
- `COE_NUMS`, {952,-1609,3090,-6260,20622}, unique coefficients listed from the outermost to the innermost tap.
- `YOUT_WIDTH`, 16, output width, signed.
- `SRA_BITS`, 15, arithmetic right shift applied to the FIR-phase sum.
- `NUM_CH`, 4, number of interleaved channels (≥1).

Ports:
- `clk` in 1: sole clock. All logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `xin_valid` in 1: input sample strobe. May be asserted every cycle.
- `xin_sof` in 1: marks the channel-0 sample. Qualified by `xin_valid`.
- `xin` in XIN_WIDTH: input sample.
- `bypass` in 1: zero-order-hold mode. Sampled together with `xin_valid`.
- `yout_valid` out 1: output strobe.
- `yout_ch` out clog2(NUM_CH) (min 1): channel of the current output.
- `yout0` out YOUT_WIDTH: FIR-phase output (high-rate time 2n).
- `yout1` out YOUT_WIDTH: center-phase output (high-rate time 2n+1).
- `ovf` out 1: saturation occurred in `yout0` or `yout1` this output.
- `ovf_sticky` out 1: OR of all `ovf` since reset.

## Operation
- **Channel counter.** The counter `ch` selects the channel for each accepted sample.
  - On `xin_valid` with `xin_sof`=1, the sample is assigned to channel 0 and `ch` becomes 1 (mod `NUM_CH`).
  - On `xin_valid` with `xin_sof`=0, the sample is assigned to channel `ch` and `ch` increments, wrapping from `NUM_CH-1` to 0.
- **History.** Each channel keeps `2N` samples, h[0..2N-1], where h[0] is the newest.
  - An accepted sample shifts only its own channel's history.
  - The computation uses the history after the shift.
- **FIR phase.** S = Σ_{k=0}^{N-1} c_k·(h[k] + h[2N-1-k]).
  - Pre-add width is XIN_WIDTH+1. The accumulator is full precision, with no intermediate truncation.
  - `yout0` = saturate((S + 2^(SRA_BITS-1)) >>> SRA_BITS) to YOUT_WIDTH. This is round half up.
- **Center phase.** `yout1` = h[N-1], sign-extended or saturated to YOUT_WIDTH. This is unity gain.
- **Overflow.** `ovf` = saturation in either phase. `ovf_sticky` is set by `ovf` and cleared only by `rst`.
- **Bypass mode.** When `bypass`=1, `yout0`=`yout1`=h[0] (saturated) and `ovf` reflects only that saturation.
  - History still updates, so leaving bypass resumes filtering with no glitch beyond the natural history.
- **Flow control.** There is no backpressure, and output order equals input order.

## Timing
- **Latency.** Fixed at 5 cycles.
  - A sample accepted on edge t appears with `yout_valid`=1 at edge t+5 and holds for one cycle.
  - The stages are: history write; pre-add; multiply; adder tree; round/saturate.
- **Throughput.** One input per cycle, two outputs per cycle. Back-to-back `xin_valid` requires no idle cycles.
- **Output data when idle.** When `yout_valid`=0, `yout0`, `yout1` and `ovf` are 0. `yout_ch` holds its last value.
- **Reset values.** `yout_valid`=0, `yout0`=0, `yout1`=0, `yout_ch`=0, `ovf`=0, `ovf_sticky`=0. All histories and the channel counter are 0.
- **Reset mid-stream.** Samples in flight are discarded and no `yout_valid` follows. After reset deasserts, the first output is computed on zero histories.
- **`xin_sof` mid-frame.** This is a resync: the counter jumps to channel 0 for that sample. Other channels' histories are untouched.
- **Fixed control mapping.** `bypass` and the channel tag travel down the pipeline with their sample, so changing `bypass` between samples affects only subsequent samples.

## Test plan
- **Impulse response.** NUM_CH=1, default coefficients. Input `xin`=-32768 once, then zeros, `xin_valid` every cycle.
  - Expect `yout0` for outputs 0..9 = -952, 1609, -3090, 6260, -20622, -20622, 6260, -3090, 1609, -952, then 0.
  - Expect `yout1` = -32768 at output 4 only.
  - Expect `yout_valid` 5 cycles after the first input, and `ovf`=0.
- **Channel isolation.** NUM_CH=3, `xin_sof` on channel 0, `xin_valid` every cycle. Apply the same -32768 impulse on channel 1 only.
  - Expect the channel-1 outputs to carry the sequence above.
  - Expect channel-0 and channel-2 outputs to be all 0.
  - Expect `yout_ch` to cycle 0, 1, 2.
- **Saturation.** Constant `xin`=32767, then later constant -32768.
  - Expect the steady-state `yout0` to be 32767 and then -32768.
  - Expect `ovf`=1 on those outputs and `ovf_sticky`=1 thereafter.
  - Expect `yout1` = 32767 and then -32768 with no `ovf` from that phase.
- **Bypass.** `bypass`=1 with inputs 100, -200, 300 → `yout0`=`yout1` = 100, -200, 300 at 5-cycle latency. Deassert `bypass` and verify the filtered output matches a model on the retained history.
- **Sparse valid and resync.** `xin_valid` every 3rd cycle gives identical output values, with valid spacing preserved. An `xin_sof` inserted mid-frame restarts the channel count at 0.
- **Reset mid-stream.** Assert `rst` for one cycle during streaming.
  - Expect no `yout_valid` for in-flight samples.
  - Expect `ovf_sticky`=0.
  - Expect the next impulse response to match the first test exactly.

Source files
------------

// File: rtl/hb_up2_mc_if.sv
// Streaming port bundle for hb_up2_mc: TDM sample input side and the dual-phase
// output side. The source/sink uses master, the filter uses slave.
interface hb_up2_mc_if #(
  parameter int XIN_WIDTH  = 16,
  parameter int YOUT_WIDTH = 16,
  parameter int NUM_CH     = 4,
  localparam int CH_WIDTH  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic                         xin_valid;
  logic                         xin_sof;
  logic signed [XIN_WIDTH-1:0]  xin;
  logic                         bypass;
  logic                         yout_valid;
  logic [CH_WIDTH-1:0]          yout_ch;
  logic signed [YOUT_WIDTH-1:0] yout0;
  logic signed [YOUT_WIDTH-1:0] yout1;
  logic                         ovf;
  logic                         ovf_sticky;

  modport master (
    output xin_valid, xin_sof, xin, bypass,
    input  yout_valid, yout_ch, yout0, yout1, ovf, ovf_sticky
  );

  modport slave (
    input  xin_valid, xin_sof, xin, bypass,
    output yout_valid, yout_ch, yout0, yout1, ovf, ovf_sticky
  );
endinterface

// File: rtl/hb_up2_mc.sv
// Multichannel half-band interpolate-by-2: per-channel histories, symmetric
// pre-add FIR phase, unity center phase, round-half-up, saturation, bypass.
module hb_up2_mc #(
  parameter int XIN_WIDTH      = 16,
  parameter int COE_WIDTH      = 16,
  parameter int NUM_UNIQUE_COE = 5,
  parameter int COE_NUMS [NUM_UNIQUE_COE] = '{952, -1609, 3090, -6260, 20622},
  parameter int YOUT_WIDTH     = 16,
  parameter int SRA_BITS       = 15,
  parameter int NUM_CH         = 4
) (
  input logic        clk,
  input logic        rst,
  hb_up2_mc_if.slave bus
);
  localparam int N          = NUM_UNIQUE_COE;
  localparam int TAPS       = 2 * N;
  localparam int CH_WIDTH   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PRE_WIDTH  = XIN_WIDTH + 1;
  localparam int PROD_WIDTH = PRE_WIDTH + COE_WIDTH;
  localparam int ACC_WIDTH  = PROD_WIDTH + $clog2(N) + 1;

  localparam logic signed [ACC_WIDTH-1:0] Y_MAX =
    {{(ACC_WIDTH-YOUT_WIDTH+1){1'b0}}, {(YOUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] Y_MIN = ~Y_MAX;
  localparam logic signed [ACC_WIDTH-1:0] ROUND = ACC_WIDTH'(1) <<< (SRA_BITS - 1);

  typedef struct packed {
    logic signed [YOUT_WIDTH-1:0] y;
    logic                         ovf;
  } sat_t;

  function automatic sat_t saturate(input logic signed [ACC_WIDTH-1:0] v);
    sat_t r;
    r.ovf = (v > Y_MAX) || (v < Y_MIN);
    if (v > Y_MAX)      r.y = Y_MAX[YOUT_WIDTH-1:0];
    else if (v < Y_MIN) r.y = Y_MIN[YOUT_WIDTH-1:0];
    else                r.y = v[YOUT_WIDTH-1:0];
    return r;
  endfunction

  // Stage 0: input capture
  logic                        v0, sof0, byp0;
  logic signed [XIN_WIDTH-1:0] x0;
  // Stage 1: history write
  logic                        v1, byp1;
  logic [CH_WIDTH-1:0]         ch1, cnt, sel;
  logic signed [XIN_WIDTH-1:0] hist [NUM_CH][TAPS];
  // Stage 2: pre-add
  logic                        v2, byp2;
  logic [CH_WIDTH-1:0]         ch2;
  logic signed [PRE_WIDTH-1:0] pre2 [N];
  logic signed [XIN_WIDTH-1:0] cen2, new2;
  // Stage 3: multiply
  logic                         v3, byp3;
  logic [CH_WIDTH-1:0]          ch3;
  logic signed [PROD_WIDTH-1:0] prod3 [N];
  logic signed [XIN_WIDTH-1:0]  cen3, new3;
  // Stage 4: adder tree
  logic                        v4, byp4;
  logic [CH_WIDTH-1:0]         ch4;
  logic signed [ACC_WIDTH-1:0] acc4, sum, rounded;
  logic signed [XIN_WIDTH-1:0] cen4, new4;
  sat_t                        s0, s1;

  // A frame marker forces channel 0 regardless of where the counter is.
  assign sel = sof0 ? '0 : cnt;

  // NOTE: every variable gets a value before any conditional use, so this
  // block stays purely combinational with no inferred latch.
  always_comb begin
    sum = '0;
    for (int k = 0; k < N; k++) sum = sum + ACC_WIDTH'(prod3[k]);
  end

  always_comb begin
    rounded = (acc4 + ROUND) >>> SRA_BITS;
    if (byp4) begin
      s0 = saturate(ACC_WIDTH'(new4));
      s1 = s0;
    end else begin
      s0 = saturate(rounded);
      s1 = saturate(ACC_WIDTH'(cen4));
    end
  end

  // NOTE: all state here uses non-blocking assignments so every stage reads
  // the previous cycle's values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      {v0, sof0, byp0, v1, byp1, v2, byp2, v3, byp3, v4, byp4} <= '0;
      x0   <= '0;
      cnt  <= '0;
      ch1  <= '0;
      ch2  <= '0;
      ch3  <= '0;
      ch4  <= '0;
      cen2 <= '0;
      new2 <= '0;
      cen3 <= '0;
      new3 <= '0;
      cen4 <= '0;
      new4 <= '0;
      acc4 <= '0;
      // NOTE: histories are cleared explicitly because the first output after
      // reset must be computed on all-zero history, which no RAM would give.
      for (int c = 0; c < NUM_CH; c++)
        for (int i = 0; i < TAPS; i++) hist[c][i] <= '0;
      for (int k = 0; k < N; k++) begin
        pre2[k]  <= '0;
        prod3[k] <= '0;
      end
      bus.yout_valid <= 1'b0;
      bus.yout_ch    <= '0;
      bus.yout0      <= '0;
      bus.yout1      <= '0;
      bus.ovf        <= 1'b0;
      bus.ovf_sticky <= 1'b0;
    end else begin
      v0   <= bus.xin_valid;
      sof0 <= bus.xin_sof;
      byp0 <= bus.bypass;
      x0   <= bus.xin;

      v1   <= v0;
      byp1 <= byp0;
      ch1  <= sel;
      if (v0) begin
        for (int i = TAPS - 1; i > 0; i--) hist[sel][i] <= hist[sel][i-1];
        hist[sel][0] <= x0;
        cnt <= (sel == CH_WIDTH'(NUM_CH - 1)) ? '0 : sel + CH_WIDTH'(1);
      end

      // Reads the history as it stood after this sample's own shift.
      v2   <= v1;
      byp2 <= byp1;
      ch2  <= ch1;
      for (int k = 0; k < N; k++)
        pre2[k] <= PRE_WIDTH'(hist[ch1][k]) + PRE_WIDTH'(hist[ch1][TAPS-1-k]);
      cen2 <= hist[ch1][N-1];
      new2 <= hist[ch1][0];

      v3   <= v2;
      byp3 <= byp2;
      ch3  <= ch2;
      for (int k = 0; k < N; k++)
        prod3[k] <= PROD_WIDTH'(pre2[k]) * PROD_WIDTH'(COE_WIDTH'(COE_NUMS[k]));
      cen3 <= cen2;
      new3 <= new2;

      v4   <= v3;
      byp4 <= byp3;
      ch4  <= ch3;
      acc4 <= sum;
      cen4 <= cen3;
      new4 <= new3;

      bus.yout_valid <= v4;
      if (v4) begin
        bus.yout_ch    <= ch4;
        bus.yout0      <= s0.y;
        bus.yout1      <= s1.y;
        bus.ovf        <= s0.ovf | s1.ovf;
        bus.ovf_sticky <= bus.ovf_sticky | s0.ovf | s1.ovf;
      end else begin
        bus.yout0 <= '0;
        bus.yout1 <= '0;
        bus.ovf   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_hb_up2_mc.sv
// Bench for hb_up2_mc (3 channels): per-cycle compare against an arithmetic
// model of the filter equations, plus literal impulse/saturation/bypass pins.
module tb_hb_up2_mc;
  localparam int NCH = 3;
  localparam int N   = 5;
  localparam int XW  = 16;
  localparam int YW  = 16;
  localparam int SRA = 15;
  localparam int COE [N] = '{952, -1609, 3090, -6260, 20622};
  localparam int IMP [11] = '{-952, 1609, -3090, 6260, -20622, -20622,
                              6260, -3090, 1609, -952, 0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hb_up2_mc_if #(.XIN_WIDTH(XW), .YOUT_WIDTH(YW), .NUM_CH(NCH)) bus ();

  hb_up2_mc #(
    .XIN_WIDTH(XW), .COE_WIDTH(16), .NUM_UNIQUE_COE(N),
    .COE_NUMS('{952, -1609, 3090, -6260, 20622}),
    .YOUT_WIDTH(YW), .SRA_BITS(SRA), .NUM_CH(NCH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct { int due; int ch; int y0; int y1; bit ovf; } exp_t;
  typedef struct { int cyc; int ch; int y0; int y1; bit ovf; } rec_t;

  exp_t expq [$];
  rec_t recs [$];
  int   hist_m [NCH][2*N];
  int   mch = 0;
  int   cyc = 0;
  int   last_ch = 0;
  bit   exp_sticky = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  int   first_in_cyc = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  function automatic int sat_y(input longint v, output bit o);
    longint hi = (longint'(1) <<< (YW - 1)) - 1;
    longint lo = -(longint'(1) <<< (YW - 1));
    o = (v > hi) || (v < lo);
    if (v > hi) return int'(hi);
    if (v < lo) return int'(lo);
    return int'(v);
  endfunction

  // Model: filter equations evaluated directly on each accepted sample.
  always @(posedge clk) begin
    longint s;
    int     c;
    bit     o0, o1;
    exp_t   e;
    cyc++;
    if (rst) begin
      expq.delete();
      mch = 0;
      last_ch = 0;
      exp_sticky = 0;
      foreach (hist_m[a, b]) hist_m[a][b] = 0;
    end else if (bus.xin_valid) begin
      c   = bus.xin_sof ? 0 : mch;
      mch = (c + 1) % NCH;
      for (int i = 2*N - 1; i > 0; i--) hist_m[c][i] = hist_m[c][i-1];
      hist_m[c][0] = int'(bus.xin);
      e.due = cyc + 5;
      e.ch  = c;
      if (bus.bypass) begin
        e.y0  = sat_y(longint'(hist_m[c][0]), o0);
        e.y1  = e.y0;
        e.ovf = o0;
      end else begin
        s = 0;
        for (int k = 0; k < N; k++)
          s += longint'(COE[k]) * longint'(hist_m[c][k] + hist_m[c][2*N-1-k]);
        e.y0  = sat_y((s + (longint'(1) <<< (SRA - 1))) >>> SRA, o0);
        e.y1  = sat_y(longint'(hist_m[c][N-1]), o1);
        e.ovf = o0 | o1;
      end
      expq.push_back(e);
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    rec_t r;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      e = expq.pop_front();
      if (e.ovf) exp_sticky = 1;
      check("yout_valid", bus.yout_valid, 1);
      check("yout_ch", bus.yout_ch, e.ch);
      check("yout0", bus.yout0, e.y0);
      check("yout1", bus.yout1, e.y1);
      check("ovf", bus.ovf, e.ovf);
      last_ch = e.ch;
      r.cyc = cyc;
      r.ch  = int'(bus.yout_ch);
      r.y0  = int'(bus.yout0);
      r.y1  = int'(bus.yout1);
      r.ovf = bus.ovf;
      recs.push_back(r);
    end else begin
      check("idle_valid", bus.yout_valid, 0);
      check("idle_yout0", bus.yout0, 0);
      check("idle_yout1", bus.yout1, 0);
      check("idle_ovf", bus.ovf, 0);
      check("idle_ch_hold", bus.yout_ch, last_ch);
    end
    check("ovf_sticky", bus.ovf_sticky, exp_sticky);
  end

  task automatic send(input bit v, input bit sof, input bit byp, input int x);
    @(negedge clk);
    bus.xin_valid = v;
    bus.xin_sof   = sof;
    bus.bypass    = byp;
    bus.xin       = XW'(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(0, 0, 0, 0);
  endtask

  task automatic send_frame(input int x0, input int x1, input int x2, input bit byp);
    send(1, 1, byp, x0);
    send(1, 0, byp, x1);
    send(1, 0, byp, x2);
  endtask

  task automatic check_impulse(input string tag);
    int k = 0;
    foreach (recs[i]) begin
      if (recs[i].ch == 1 && k < 11) begin
        check({tag, "_y0"}, recs[i].y0, IMP[k]);
        check({tag, "_y1"}, recs[i].y1, (k == 4) ? -32768 : 0);
        k++;
      end else if (recs[i].ch != 1) begin
        check({tag, "_other_ch_y0"}, recs[i].y0, 0);
      end
    end
    check({tag, "_count"}, k, 11);
  endtask

  task automatic impulse_run(input string tag);
    recs.delete();
    for (int f = 0; f < 14; f++) begin
      send(1, 1, 0, 0);
      send(1, 0, 0, (f == 0) ? -32768 : 0);
      if (f == 0) first_in_cyc = cyc + 1;
      send(1, 0, 0, 0);
    end
    idle(8);
    check_impulse(tag);
  endtask

  initial begin
    rec_t r;
    bus.xin_valid = 0;
    bus.xin_sof   = 0;
    bus.bypass    = 0;
    bus.xin       = '0;
    rst = 1;
    idle(2);
    check("reset_valid", bus.yout_valid, 0);
    check("reset_yout0", bus.yout0, 0);
    check("reset_ch", bus.yout_ch, 0);
    check("reset_sticky", bus.ovf_sticky, 0);
    rst = 0;
    idle(2);

    // Impulse on channel 1 only; channels 0 and 2 must stay silent.
    impulse_run("impulse");
    check("impulse_latency", recs[1].cyc - first_in_cyc, 5);
    for (int i = 0; i < 6; i++) check("ch_rotation", recs[i].ch, i % NCH);
    check("impulse_ovf", recs[5].ovf, 0);

    // Sparse valid: one sample every third cycle, same values, spacing kept.
    recs.delete();
    for (int f = 0; f < 12; f++) begin
      send(1, 1, 0, 0); idle(2);
      send(1, 0, 0, (f == 0) ? -32768 : 0); idle(2);
      send(1, 0, 0, 0); idle(2);
    end
    idle(8);
    check_impulse("sparse");
    for (int i = 0; i < 4; i++) check("sparse_spacing", recs[i+1].cyc - recs[i].cyc, 3);

    // Mid-frame resync restarts the count at channel 0.
    recs.delete();
    send(1, 1, 0, 7);
    send(1, 0, 0, 8);
    send(1, 1, 0, 9);
    send(1, 0, 0, 0);
    send(1, 0, 0, 0);
    idle(8);
    check("resync_ch2", recs[2].ch, 0);
    check("resync_ch3", recs[3].ch, 1);
    check("resync_ch4", recs[4].ch, 2);

    // Saturation at both rails.
    recs.delete();
    for (int f = 0; f < 12; f++) send_frame(32767, 32767, 32767, 0);
    idle(8);
    r = recs[recs.size()-1];
    check("sat_pos_y0", r.y0, 32767);
    check("sat_pos_y1", r.y1, 32767);
    check("sat_pos_ovf", r.ovf, 1);
    check("sat_pos_sticky", bus.ovf_sticky, 1);
    recs.delete();
    for (int f = 0; f < 12; f++) send_frame(-32768, -32768, -32768, 0);
    idle(8);
    r = recs[recs.size()-1];
    check("sat_neg_y0", r.y0, -32768);
    check("sat_neg_y1", r.y1, -32768);
    check("sat_neg_ovf", r.ovf, 1);

    // Bypass, then resume filtering on the retained history.
    recs.delete();
    send_frame(100, -200, 300, 1);
    idle(8);
    check("byp_y0_0", recs[0].y0, 100);
    check("byp_y1_0", recs[0].y1, 100);
    check("byp_y0_1", recs[1].y0, -200);
    check("byp_y1_1", recs[1].y1, -200);
    check("byp_y0_2", recs[2].y0, 300);
    check("byp_ovf", recs[2].ovf, 0);
    for (int f = 0; f < 4; f++) send_frame(1000 * f, -700, 12345, 0);
    idle(8);

    // Reset mid-stream: in-flight samples vanish, sticky clears.
    for (int f = 0; f < 2; f++) send_frame(500, 500, 500, 0);
    @(negedge clk);
    bus.xin_valid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    recs.delete();
    idle(8);
    check("rst_no_outputs", recs.size(), 0);
    check("rst_sticky", bus.ovf_sticky, 0);
    impulse_run("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
